// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared constants, opcodes and state encoding for the instruction sequencer
package instr_sequencer_pkg;

  localparam int DEPTH    = 32;
  localparam int AW       = $clog2(DEPTH);
  localparam int WAIT_MAX = 7;
  localparam int WCW      = $clog2(WAIT_MAX + 1);

  // Stop word; opcode 111 is never used by the processor, so it cannot collide.
  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  // Processor opcodes, instruction bits [15:13].
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - control, load and processor-facing signals of the instruction sequencer
interface instr_sequencer_if;
  import instr_sequencer_pkg::*;

  logic          start;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic          done;
  logic [15:0]   din;
  logic          run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          timeout;
  logic [15:0]   instr_count;

  // Controller / processor side that drives start, loads and done.
  modport master (
    output start, load_en, load_addr, load_data, done,
    input  din, run, pc, busy, halted, timeout, instr_count
  );

  // Sequencer side.
  modport slave (
    input  start, load_en, load_addr, load_data, done,
    output din, run, pc, busy, halted, timeout, instr_count
  );

endinterface

// File: rtl/instr_sequencer_prog_ram.sv
// rtl/instr_sequencer_prog_ram.sv - program memory, synchronous write and asynchronous read
module prog_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write port; contents deliberately survive reset so a program can be rerun.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - issues program words one at a time to the processor and waits for done
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  instr_sequencer_if.slave   bus
);

  localparam logic [AW-1:0]  LAST_PC    = AW'(DEPTH - 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(WAIT_MAX - 1);

  state_e         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [15:0]    icnt_q, icnt_d;
  logic [15:0]    din_q, din_d;

  logic [15:0]    rd_data;
  logic           ram_we;
  logic           is_halt;
  logic           can_start;

  // Loads and starts are only honoured while nothing is in flight.
  assign can_start = (state_q == ST_IDLE) || (state_q == ST_HALT) || (state_q == ST_ERROR);
  assign ram_we    = bus.load_en && can_start;
  assign is_halt   = (rd_data == HALT_WORD);

  prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (16)
  ) u_prog_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (bus.load_addr),
    .wdata_i (bus.load_data),
    .raddr_i (pc_q),
    .rdata_o (rd_data)
  );

  assign bus.pc          = pc_q;
  assign bus.instr_count = icnt_q;

  // State, PC, wait counter, instruction count and held instruction register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      wcnt_q  <= '0;
      icnt_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wcnt_q  <= wcnt_d;
      icnt_q  <= icnt_d;
      din_q   <= din_d;
    end
  end

  // Next-state and output decode; din_q keeps the last issued word so DIN holds in WAIT/HALT/ERROR.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wcnt_d      = wcnt_q;
    icnt_d      = icnt_q;
    din_d       = din_q;
    bus.din     = din_q;
    bus.run     = 1'b0;
    bus.busy    = 1'b0;
    bus.halted  = 1'b0;
    bus.timeout = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ISSUE;
          pc_d    = '0;
          icnt_d  = '0;
        end
      end

      ST_ISSUE: begin
        bus.busy = 1'b1;
        bus.din  = rd_data;
        din_d    = rd_data;
        if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          bus.run = 1'b1;
          state_d = ST_WAIT;
          wcnt_d  = '0;
        end
      end

      ST_WAIT: begin
        bus.busy = 1'b1;
        if (bus.done) begin
          icnt_d = (icnt_q == 16'hFFFF) ? icnt_q : icnt_q + 16'd1;
          if (pc_q == LAST_PC) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = ST_ISSUE;
          end
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
          if (wcnt_q == WAIT_LIMIT) begin
            state_d = ST_ERROR;
          end
        end
      end

      ST_HALT, ST_ERROR: begin
        bus.halted  = (state_q == ST_HALT);
        bus.timeout = (state_q == ST_ERROR);
        if (bus.start) begin
          state_d = ST_ISSUE;
          pc_d    = '0;
          icnt_d  = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench with a transaction-level program model and processor responder
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // WAIT cycles the processor spends on an instruction.
  function automatic int latency(input logic [15:0] w);
    logic [2:0] op;
    op = w[15:13];
    return (op == OP_ADD || op == OP_SUB) ? 3 : 1;
  endfunction

  task automatic load_all();
    for (int i = 0; i < DEPTH; i++) begin
      bus.load_en   = 1'b1;
      bus.load_addr = AW'(i);
      bus.load_data = model_mem[i];
      @(negedge clk);
    end
    bus.load_en = 1'b0;
  endtask

  // Runs the loaded program from Start and compares issue timing, words and final status with the model.
  task automatic exec_program(input string tag, input int stall_idx, input bit busy_wr,
                              input bit start_wr, input logic [15:0] start_wr_data);
    int          exp_t[$];
    logic [15:0] exp_d[$];
    int          got_t[$];
    logic [15:0] got_d[$];
    int          t, pc, cnt, end_t, wait_left, c, end_seen, overlaps, n;
    bit          exp_err, stop, finished, prev_run;
    logic [15:0] orig0;

    if (start_wr) model_mem[0] = start_wr_data;
    orig0 = model_mem[0];
    t = 0; pc = 0; cnt = 0; exp_err = 0; stop = 0; end_t = 0;
    while (!stop) begin
      if (model_mem[pc] == HALT_WORD) begin
        end_t = t + 1;
        stop  = 1;
      end else begin
        exp_t.push_back(t);
        exp_d.push_back(model_mem[pc]);
        if (pc == stall_idx) begin
          exp_err = 1;
          end_t   = t + 1 + WAIT_MAX;
          stop    = 1;
        end else begin
          t   = t + 1 + latency(model_mem[pc]);
          cnt = cnt + 1;
          if (pc == DEPTH - 1) begin
            end_t = t;
            stop  = 1;
          end else begin
            pc = pc + 1;
          end
        end
      end
    end

    bus.start = 1'b1;
    if (start_wr) begin
      bus.load_en   = 1'b1;
      bus.load_addr = '0;
      bus.load_data = start_wr_data;
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    wait_left = 0; prev_run = 0; finished = 0; c = 0; end_seen = -1; overlaps = 0;
    while (!finished && c < 600) begin
      if (bus.run) begin
        got_t.push_back(c);
        got_d.push_back(bus.din);
        if (prev_run) overlaps++;
      end
      if (bus.halted || bus.timeout) begin
        finished = 1;
        end_seen = c;
      end
      if (bus.run) begin
        wait_left = (got_t.size() - 1 == stall_idx) ? 1000000 : latency(bus.din);
        bus.done  = 1'b0;
      end else if (wait_left > 0) begin
        bus.done  = (wait_left == 1);
        wait_left = wait_left - 1;
      end else begin
        bus.done = 1'b0;
      end
      if (busy_wr && c == 1) begin
        bus.load_en   = 1'b1;
        bus.load_addr = '0;
        bus.load_data = orig0 ^ 16'h00F0;
      end else begin
        bus.load_en = 1'b0;
      end
      prev_run = bus.run;
      c++;
      @(negedge clk);
    end
    bus.done    = 1'b0;
    bus.load_en = 1'b0;

    chk({tag, ":finished"},   32'(finished), 32'd1);
    chk({tag, ":end_cycle"},  32'(end_seen), 32'(end_t));
    chk({tag, ":issues"},     32'(got_t.size()), 32'(exp_t.size()));
    n = (got_t.size() < exp_t.size()) ? got_t.size() : exp_t.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s:issue%0d_cycle", tag, i), 32'(got_t[i]), 32'(exp_t[i]));
      chk($sformatf("%s:issue%0d_din", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
    end
    chk({tag, ":run_back2back"}, 32'(overlaps), 32'd0);
    chk({tag, ":halted"},  32'(bus.halted), 32'(!exp_err));
    chk({tag, ":timeout"}, 32'(bus.timeout), 32'(exp_err));
    chk({tag, ":pc"},      32'(bus.pc), 32'(pc));
    chk({tag, ":count"},   32'(bus.instr_count), 32'(cnt));
    chk({tag, ":busy"},    32'(bus.busy), 32'd0);
  endtask

  task automatic set_prog(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = HALT_WORD;
    model_mem[0] = w0;
    model_mem[1] = w1;
    model_mem[2] = w2;
  endtask

  initial begin
    int len, stall;
    bus.start = 1'b0; bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0; bus.done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("reset:run",     32'(bus.run), 32'd0);
    chk("reset:busy",    32'(bus.busy), 32'd0);
    chk("reset:halted",  32'(bus.halted), 32'd0);
    chk("reset:timeout", 32'(bus.timeout), 32'd0);
    chk("reset:pc",      32'(bus.pc), 32'd0);
    chk("reset:count",   32'(bus.instr_count), 32'd0);
    chk("reset:din",     32'(bus.din), 32'd0);

    bus.done = 1'b1;
    repeat (3) @(negedge clk);
    bus.done = 1'b0;
    chk("idle_done:busy", 32'(bus.busy), 32'd0);
    chk("idle_done:pc",   32'(bus.pc), 32'd0);

    set_prog(16'h1005, HALT_WORD, HALT_WORD);
    load_all();
    exec_program("t1", -1, 0, 0, 16'h0);

    bus.done = 1'b1;
    repeat (3) @(negedge clk);
    bus.done = 1'b0;
    chk("halt_done:halted", 32'(bus.halted), 32'd1);
    chk("halt_done:pc",     32'(bus.pc), 32'd1);
    chk("halt_done:count",  32'(bus.instr_count), 32'd1);

    set_prog(16'h1005, 16'h5003, HALT_WORD);
    load_all();
    exec_program("t2", -1, 0, 0, 16'h0);
    exec_program("t6_busy_load", -1, 1, 0, 16'h0);
    exec_program("t6_ram_unchanged", -1, 0, 0, 16'h0);
    exec_program("t3_timeout", 0, 0, 0, 16'h0);
    exec_program("t3_recover", -1, 0, 0, 16'h0);

    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.done = 1'b1;
    @(negedge clk); bus.done = 1'b0;
    @(negedge clk);
    chk("t5:pre_busy",  32'(bus.busy), 32'd1);
    chk("t5:pre_pc",    32'(bus.pc), 32'd1);
    chk("t5:pre_count", 32'(bus.instr_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5:rst_busy",  32'(bus.busy), 32'd0);
    chk("t5:rst_run",   32'(bus.run), 32'd0);
    chk("t5:rst_pc",    32'(bus.pc), 32'd0);
    chk("t5:rst_count", 32'(bus.instr_count), 32'd0);
    chk("t5:rst_din",   32'(bus.din), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    exec_program("t5_rerun", -1, 0, 0, 16'h0);

    exec_program("t6_start_load", -1, 0, 1, 16'h1ABC);

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h1005;
    load_all();
    exec_program("t4_full", -1, 0, 0, 16'h0);

    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(32, 1);
      for (int i = 0; i < DEPTH; i++) begin
        model_mem[i] = {3'($urandom_range(3, 0)), 13'($urandom)};
      end
      if (len < DEPTH) model_mem[len] = HALT_WORD;
      stall = ($urandom_range(3, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
      load_all();
      exec_program($sformatf("rand%0d", r), stall, 0, 0, 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
